// File: rtl/btb_pkg.sv
// Shared BTB definitions: address slicing and the update-queue entry layout.
package btb_pkg;

    localparam int BTB_TAG_W = 23;
    localparam int BTB_IDX_W = 7;

    localparam int BTB_TAG_MSB = 31;
    localparam int BTB_TAG_LSB = 9;
    localparam int BTB_IDX_MSB = 8;
    localparam int BTB_IDX_LSB = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        valid;
    } btb_entry_t;

    function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[BTB_IDX_MSB:BTB_IDX_LSB];
    endfunction

    function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[BTB_TAG_MSB:BTB_TAG_LSB];
    endfunction

endpackage

// File: rtl/btb_uq_match.sv
// Parallel PC comparator over all queue entries; the head being popped this
// cycle never matches, so a race with the drain allocates a fresh entry.
module btb_uq_match #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0][31:0] pc_i,
    input  logic [DEPTH-1:0]       valid_i,
    input  logic [PTR_W-1:0]       head_i,
    input  logic                   pop_i,
    input  logic [31:0]            req_pc_i,
    output logic [DEPTH-1:0]       match_vec_o,
    output logic [PTR_W-1:0]       match_idx_o,
    output logic                   match_o
);

    always_comb begin
        match_vec_o = '0;
        match_idx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec_o[i] = valid_i[i] && (pc_i[i] == req_pc_i)
                             && !(pop_i && (head_i == PTR_W'(i)));
        end
        // PCs stay unique in the queue, so the vector is at most one-hot.
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec_o[i]) match_idx_o = PTR_W'(i);
        end
        match_o = |match_vec_o;
    end

endmodule

// File: rtl/btb_update_queue.sv
// Queue of resolved taken-branch updates between execute and the BTB write
// port: filters correct predictions, coalesces repeat PCs, drains one per cycle.
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DROP_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BPU__Stall,
    input  logic              Resolve_Valid,
    input  logic              Resolve_Taken,
    input  logic [31:0]       Resolve_PC,
    input  logic [31:0]       Resolve_Target,
    input  logic              Resolve_Pred_Hit,
    input  logic [31:0]       Resolve_Pred_Target,
    input  logic              Flush,
    output logic [31:0]       BTB_Write_Addr,
    output logic [31:0]       BTB_Write_Data,
    output logic              BTB_Write_En,
    output logic              Queue_Full,
    output logic              Queue_Empty,
    output logic [DROP_W-1:0] Drop_Count
);

    btb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [DEPTH-1:0][31:0] pc_vec;
    logic [DEPTH-1:0]       valid_vec;
    logic [DEPTH-1:0]       match_vec;
    logic [PTR_W-1:0]       match_idx;
    logic                   match;
    logic                   req, pop, push, drop, coalesce;

    assign Queue_Empty = (count_q == '0);
    assign Queue_Full  = (count_q == (PTR_W+1)'(DEPTH));

    assign pop          = ~Queue_Empty & ~BPU__Stall & ~RST;
    assign BTB_Write_En = pop;

    assign BTB_Write_Addr = Queue_Empty ? 32'h0 : entries_q[rd_ptr_q].pc;
    assign BTB_Write_Data = Queue_Empty ? 32'h0 : entries_q[rd_ptr_q].target;

    assign req = Resolve_Valid & Resolve_Taken
                 & ~(Resolve_Pred_Hit & (Resolve_Pred_Target == Resolve_Target));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pc_vec[i]    = entries_q[i].pc;
            valid_vec[i] = entries_q[i].valid;
        end
    end

    btb_uq_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .pc_i        (pc_vec),
        .valid_i     (valid_vec),
        .head_i      (rd_ptr_q),
        .pop_i       (pop),
        .req_pc_i    (Resolve_PC),
        .match_vec_o (match_vec),
        .match_idx_o (match_idx),
        .match_o     (match)
    );

    // A full queue still accepts a push when the head drains in the same cycle.
    assign coalesce = req & match;
    assign push     = req & ~match & (~Queue_Full | pop);
    assign drop     = req & ~match & Queue_Full & ~pop;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        drop_d   = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (Flush) begin
                for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
            end else begin
                if (pop) entries_q[rd_ptr_q].valid <= 1'b0;
                if (coalesce) entries_q[match_idx].target <= Resolve_Target;
                // Ordered after the pop so a full-with-pop push revalidates the slot.
                if (push) entries_q[wr_ptr_q] <= '{pc: Resolve_PC, target: Resolve_Target, valid: 1'b1};
            end
        end
    end

    assign Drop_Count = drop_q;

    logic unused_match_vec;
    assign unused_match_vec = ^match_vec;

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
Buffers resolved taken branches from the execute stage and drains them, one per cycle, into the branch target buffer write port (BTB_Write_Addr / BTB_Write_Data / BTB_Write_En).
- Filters out updates that the BTB already predicted correctly.
- Coalesces repeat updates to the same PC.
- Holds entries while the BPU is stalled.
- Sits directly upstream of the BTB, between branch resolution and the BTB write side.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)
DROP_W, 8, width of saturating drop counter

Ports:
CLK  in  1  clock
RST  in  1  reset
BPU__Stall  in  1  BPU stall; no drain while high
Resolve_Valid  in  1  a branch/jump resolved this cycle
Resolve_Taken  in  1  resolved outcome taken
Resolve_PC  in  32  PC of resolved instruction
Resolve_Target  in  32  actual target
Resolve_Pred_Hit  in  1  BTB hit carried with the instruction
Resolve_Pred_Target  in  32  BTB target carried with the instruction
Flush  in  1  discard all queued entries
BTB_Write_Addr  out  32  head entry PC
BTB_Write_Data  out  32  head entry target
BTB_Write_En  out  1  head valid and draining
Queue_Full  out  1  all entries valid
Queue_Empty  out  1  no entries valid
Drop_Count  out  DROP_W  updates lost because the queue was full (saturating)

Behaviour:
- Clocking and reset: CLK, reset RST, synchronous, active-high. On RST, all entries are invalidated and read/write pointers and count clear to 0. Drop_Count resets to 0. Outputs after reset: BTB_Write_En=0, Queue_Empty=1, Queue_Full=0, BTB_Write_Addr=BTB_Write_Data=0. RST asserted mid-operation discards all contents at that edge.
- Storage: circular buffer of {pc[31:0], target[31:0], valid}, with rd_ptr, wr_ptr and count[PTR_W:0]. Pointers wrap modulo DEPTH.
- Enqueue request: req = Resolve_Valid & Resolve_Taken & ~(Resolve_Pred_Hit & Resolve_Pred_Target==Resolve_Target). Not-taken or correctly-predicted resolutions are ignored.
- Drain:
  - BTB_Write_En = ~Queue_Empty & ~BPU__Stall & ~RST (combinational).
  - BTB_Write_Addr/Data reflect the head entry combinationally and are 0 when empty.
  - pop = BTB_Write_En; on pop, rd_ptr advances at the edge.
  - This matches the BTB, which samples its write inputs only when ~BPU__Stall.
- Coalesce:
  - If req and Resolve_PC equals the pc of any valid entry other than the entry being popped this cycle, that entry's target is overwritten with Resolve_Target. No new entry is allocated and count is unchanged.
  - A match only against the head being popped counts as no match, so a fresh entry is enqueued.
  - At most one match is possible, because coalescing keeps PCs unique.
- Push: req & ~match allocates at wr_ptr when count<DEPTH, or when count==DEPTH and pop occurs in the same cycle (full with simultaneous pop is accepted).
- Drop: req & ~match & full & ~pop leaves the queue unchanged and increments Drop_Count, saturating at all-ones.
- Count update: count += push - pop. Queue_Full = (count==DEPTH); Queue_Empty = (count==0). Both flags are registered-state derived, with no same-cycle bypass: an entry pushed this cycle is visible at the head next cycle at the earliest. Latency from resolve to BTB_Write_En is 1 cycle minimum.
- Flush:
  - Clears all entries and pointers at the edge and beats any same-cycle push or coalesce.
  - A pop in the flush cycle still presents BTB_Write_En=1 that cycle; the BTB captures it.
  - Drop_Count is not cleared by Flush.
- No state machine beyond queue occupancy; all state updates are at the CLK posedge.

Decomposition:
- Shared package btb_pkg: BTB_TAG_W=23 and BTB_IDX_W=7 constants, entry typedef {pc, target, valid}, address-slice localparams ([31:9] tag, [8:2] index).
- One sub-module, btb_uq_match: a DEPTH-wide parallel PC comparator. It returns a one-hot match vector and its encoded index, with the popping head masked out.

Test Plan:
- Single update: RST, then Resolve_Valid=1, Taken=1, PC=0x1000, Target=0x2000, Pred_Hit=0, Stall=0. Next cycle BTB_Write_En=1, Addr=0x1000, Data=0x2000; the cycle after, Queue_Empty=1.
- Filter: Taken=1, Pred_Hit=1, Pred_Target==Target=0x2000 → no enqueue, Queue_Empty stays 1. The same with Taken=0 → no enqueue.
- Stall and coalesce:
  - Hold Stall=1; push PC 0x10/0x20/0x30/0x40 → Queue_Full=1, BTB_Write_En=0.
  - Push PC 0x20 with Target 0x99 → count stays 4, entry 1 target becomes 0x99.
  - Push PC 0x50 → Drop_Count=1.
  - Release Stall → four writes in order 0x10, 0x20/0x99, 0x30, 0x40 on consecutive cycles.
- Full with simultaneous pop: count=4, Stall=0, push PC 0x60 in the same cycle → accepted, Drop_Count unchanged, 0x60 drains fifth.
- Head-match race: a single entry PC 0x10 is popping; push PC 0x10 with Target 0x77 the same cycle → a new entry is created and written next cycle with Data=0x77.
- Flush/RST mid-operation: 3 entries queued, Flush=1 together with a new push → Queue_Empty=1 next cycle, no further BTB_Write_En, Drop_Count retained. RST → Drop_Count=0.
